phy_recv_deframer: RTL and testbench

- Receive-side counterpart of the xmit path. Takes the 4-bit PHY nibble stream plus its data-valid, strips preamble/SFD and reassembles bytes.
- Delivers bytes to the frame buffer with a per-byte valid strobe.
- Issues one 24-bit control block per frame at end-of-frame, carrying length and status in the same layout the xmit control path consumes.
- Sits between the PHY receive pins and the receive-side frame buffer/controller, in the clk_phy domain.

---
 rtl/phy_recv_deframer.sv | 180 ++++++++++++++++++
 tb/tb_phy_recv_deframer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/phy_recv_deframer.sv
// Purpose: strips preamble/SFD from the PHY nibble stream and rebuilds bytes; one 24-bit ctrl block per frame (RECV_FCS_CHECK_EN adds CRC-32 FCS check).
// Latency: byte strobe 1 cycle after its high nibble; ctrl strobe 1 cycle after phy_rx_dv falls.
// Backpressure: none; every r_data_valid / r_ctrl_valid strobe must be consumed when issued.
module phy_recv_deframer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int PRE_MIN = 2
) (
    input  logic        clk_phy,
    input  logic        reset,
    input  logic [3:0]  phy_data_in,
    input  logic        phy_rx_dv,
    output logic [7:0]  r_data_out,
    output logic        r_data_valid,
    output logic [23:0] r_ctrl_out,
    output logic        r_ctrl_valid,
    output logic [15:0] r_frame_cnt
);

    localparam logic [11:0] MIN_L = MIN_LEN[11:0];
    localparam logic [11:0] MAX_L = MAX_LEN[11:0];
    localparam logic [3:0]  PRE_L = PRE_MIN[3:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DONE,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        wait_idle;
    logic [3:0]  pre_cnt;
    logic        phase;
    logic [3:0]  low_nib;
    logic [11:0] byte_cnt;
    logic        fcs_err;

    logic        sfd_hit;
    logic        data_vld_nxt;
    logic        ctrl_vld_nxt;
    logic [23:0] ctrl_nxt;
    logic        frame_ok;

    always_ff @(posedge clk_phy) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                // The first cycle out of reset may land mid-frame; never lock onto it.
                if (phy_rx_dv) begin
                    state_nxt = (!wait_idle && phy_data_in == 4'h5) ? S_PREAMBLE : S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (phy_rx_dv && phy_data_in == 4'h5) begin
                    state_nxt = S_PREAMBLE;
                end else if (phy_rx_dv && phy_data_in == 4'hD && pre_cnt >= PRE_L) begin
                    state_nxt = S_DATA;
                end else begin
                    state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!phy_rx_dv) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!phy_rx_dv) begin
                    state_nxt = S_IDLE;
                end else if (phy_data_in == 4'h5) begin
                    state_nxt = S_PREAMBLE;
                end else begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (!phy_rx_dv) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        sfd_hit      = (state == S_PREAMBLE) && (state_nxt == S_DATA);
        data_vld_nxt = (state == S_DATA) && phy_rx_dv && phase && (byte_cnt < MAX_L);
        ctrl_vld_nxt = (state == S_DATA) && !phy_rx_dv;
        ctrl_nxt     = {byte_cnt, 8'h00, fcs_err, (byte_cnt > MAX_L), (byte_cnt < MIN_L), phase};
        frame_ok     = ctrl_vld_nxt && (ctrl_nxt[3:0] == 4'h0);
    end

    always_ff @(posedge clk_phy) begin
        if (!reset) begin
            wait_idle    <= 1'b1;
            pre_cnt      <= 4'd0;
            phase        <= 1'b0;
            low_nib      <= 4'd0;
            byte_cnt     <= 12'd0;
            r_data_out   <= 8'd0;
            r_data_valid <= 1'b0;
            r_ctrl_out   <= 24'd0;
            r_ctrl_valid <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            wait_idle    <= 1'b0;
            r_data_valid <= data_vld_nxt;
            r_ctrl_valid <= ctrl_vld_nxt;
            if (data_vld_nxt) begin
                r_data_out <= {phy_data_in, low_nib};
            end
            if (ctrl_vld_nxt) begin
                r_ctrl_out <= ctrl_nxt;
            end
            if (frame_ok) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (state_nxt == S_PREAMBLE) begin
                if (state == S_PREAMBLE) begin
                    pre_cnt <= (pre_cnt == 4'hF) ? pre_cnt : pre_cnt + 4'd1;
                end else begin
                    pre_cnt <= 4'd1;
                end
            end
            if (sfd_hit) begin
                phase    <= 1'b0;
                byte_cnt <= 12'd0;
            end else if (state == S_DATA && phy_rx_dv) begin
                // Oversize bytes are still counted so the reported length stays true.
                phase <= ~phase;
                if (!phase) begin
                    low_nib <= phy_data_in;
                end else if (byte_cnt != 12'hFFF) begin
                    byte_cnt <= byte_cnt + 12'd1;
                end
            end
        end
    end

`ifdef RECV_FCS_CHECK_EN
    logic [31:0] crc_q;
    logic [31:0] crc_nxt;
    logic [31:0] crc_rev;

    // Reflected CRC-32, one nibble per cycle, LSB first.
    always_comb begin
        crc_nxt = crc_q ^ {28'd0, phy_data_in};
        for (int i = 0; i < 4; i++) begin
            crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ 32'hEDB88320) : (crc_nxt >> 1);
        end
    end

    always_ff @(posedge clk_phy) begin
        if (!reset) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (sfd_hit) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (state == S_DATA && phy_rx_dv) begin
            crc_q <= crc_nxt;
        end
    end

    assign crc_rev = {<<{crc_q}};
    assign fcs_err = (crc_rev != 32'hC704DD7B);
`else
    assign fcs_err = 1'b0;
`endif

endmodule

// File: tb/tb_phy_recv_deframer.sv
// Directed-vector bench for phy_recv_deframer: stimulus pushes expected bytes/ctrl words,
// a negedge monitor pops and compares every strobe the DUT emits.
module tb_phy_recv_deframer;

    localparam int MAX_LEN = 1518;

    logic        clk_phy = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  phy_data_in = 4'h0;
    logic        phy_rx_dv = 1'b0;
    logic [7:0]  r_data_out;
    logic        r_data_valid;
    logic [23:0] r_ctrl_out;
    logic        r_ctrl_valid;
    logic [15:0] r_frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_bytes[$];
    logic [23:0] exp_ctrl[$];
    logic [15:0] exp_fc[$];
    logic [7:0]  frame_buf [0:2047];

    logic        snap_req = 1'b0;
    logic [15:0] snap_fc = 16'd0;
    logic        end_req = 1'b0;

    phy_recv_deframer dut (
        .clk_phy      (clk_phy),
        .reset        (reset),
        .phy_data_in  (phy_data_in),
        .phy_rx_dv    (phy_rx_dv),
        .r_data_out   (r_data_out),
        .r_data_valid (r_data_valid),
        .r_ctrl_out   (r_ctrl_out),
        .r_ctrl_valid (r_ctrl_valid),
        .r_frame_cnt  (r_frame_cnt)
    );

    always #5 clk_phy = ~clk_phy;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_phy) begin
        logic [7:0]  eb;
        logic [23:0] ec;
        logic [15:0] ef;
        if (r_data_valid) begin
            if (exp_bytes.size() == 0) begin
                cmp("data_unexpected", {24'd0, r_data_out}, 32'hFFFF_FFFF);
            end else begin
                eb = exp_bytes.pop_front();
                cmp("data_byte", {24'd0, r_data_out}, {24'd0, eb});
            end
        end
        if (r_ctrl_valid) begin
            cmp("strobe_overlap", {31'd0, r_data_valid}, 32'd0);
            cmp("bytes_pending_at_ctrl", exp_bytes.size(), 32'd0);
            if (exp_ctrl.size() == 0) begin
                cmp("ctrl_unexpected", {8'd0, r_ctrl_out}, 32'hFFFF_FFFF);
            end else begin
                ec = exp_ctrl.pop_front();
                ef = exp_fc.pop_front();
                cmp("ctrl_word", {8'd0, r_ctrl_out}, {8'd0, ec});
                cmp("frame_cnt", {16'd0, r_frame_cnt}, {16'd0, ef});
            end
        end
        if (snap_req) begin
            cmp("snap_data_valid", {31'd0, r_data_valid}, 32'd0);
            cmp("snap_ctrl_valid", {31'd0, r_ctrl_valid}, 32'd0);
            cmp("snap_data_out", {24'd0, r_data_out}, 32'd0);
            cmp("snap_ctrl_out", {8'd0, r_ctrl_out}, 32'd0);
            cmp("snap_frame_cnt", {16'd0, r_frame_cnt}, {16'd0, snap_fc});
        end
        if (end_req) begin
            cmp("leftover_bytes", exp_bytes.size(), 32'd0);
            cmp("leftover_ctrl", exp_ctrl.size(), 32'd0);
        end
    end

    task automatic send_nib(input logic dv, input logic [3:0] n);
        phy_rx_dv   = dv;
        phy_data_in = n;
        @(posedge clk_phy);
        #1;
    endtask

    task automatic send_pre(input int n, input logic [3:0] sfd);
        for (int i = 0; i < n; i++) send_nib(1'b1, 4'h5);
        send_nib(1'b1, sfd);
    endtask

    task automatic send_bytes(input int first, input int last, input bit expect_out);
        logic [7:0] b;
        for (int i = first; i < last; i++) begin
            b = frame_buf[i];
            if (expect_out && i < MAX_LEN) exp_bytes.push_back(b);
            send_nib(1'b1, b[3:0]);
            send_nib(1'b1, b[7:4]);
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) send_nib(1'b0, 4'h0);
    endtask

    task automatic fill_seq(input int seed);
        for (int i = 0; i < 2048; i++) frame_buf[i] = 8'(i * 7 + seed);
    endtask

    task automatic fill_nominal();
        for (int i = 0; i < 64; i++) frame_buf[i] = (i < 4 || i >= 60) ? 8'hFF : 8'h00;
    endtask

    task automatic expect_ctrl(input logic [23:0] c, input logic [15:0] fc);
        exp_ctrl.push_back(c);
        exp_fc.push_back(fc);
    endtask

    task automatic good_frame(input int nbytes, input logic [23:0] c, input logic [15:0] fc);
        expect_ctrl(c, fc);
        send_pre(7, 4'hD);
        send_bytes(0, nbytes, 1'b1);
        gap(4);
    endtask

    initial begin
        // Reset held with dv toggling.
        for (int i = 0; i < 3; i++) send_nib(1'(i), 4'h5);
        snap_fc  = 16'd0;
        snap_req = 1'b1;
        send_nib(1'b1, 4'h5);
        snap_req = 1'b0;

        // Release mid-stream: DUT must ignore the rest of this frame.
        fill_seq(1);
        reset = 1'b1;
        send_pre(7, 4'hD);
        send_bytes(0, 10, 1'b0);
        gap(3);

        fill_nominal();
        good_frame(64, 24'h040000, 16'd1);

        fill_seq(16);
        good_frame(10, 24'h00A002, 16'd1);

        // Odd nibble: leftover nibble dropped.
        fill_seq(3);
        expect_ctrl(24'h040001, 16'd1);
        send_pre(7, 4'hD);
        send_bytes(0, 64, 1'b1);
        send_nib(1'b1, 4'hA);
        gap(4);

        // Bad preamble nibble, then SFD after a single 0x5.
        send_nib(1'b1, 4'h5);
        send_nib(1'b1, 4'h3);
        send_pre(5, 4'hD);
        send_bytes(0, 8, 1'b0);
        gap(3);
        send_pre(1, 4'hD);
        send_bytes(0, 8, 1'b0);
        gap(3);
        good_frame(64, 24'h040000, 16'd2);

        // Back-to-back with a single-cycle dv gap.
        fill_seq(9);
        expect_ctrl(24'h040000, 16'd3);
        send_pre(7, 4'hD);
        send_bytes(0, 64, 1'b1);
        gap(1);
        expect_ctrl(24'h040000, 16'd4);
        send_pre(7, 4'hD);
        send_bytes(0, 64, 1'b1);
        gap(4);

        // Zero-byte frame.
        expect_ctrl(24'h000002, 16'd4);
        send_pre(7, 4'hD);
        gap(4);

        // Length boundaries around MAX_LEN.
        fill_seq(5);
        good_frame(1518, 24'h5EE000, 16'd5);
        good_frame(1519, 24'h5EF004, 16'd5);

        // Reset at byte 30 of a frame; no ctrl strobe, counter cleared.
        fill_seq(11);
        send_pre(7, 4'hD);
        send_bytes(0, 30, 1'b1);
        reset = 1'b0;
        send_bytes(30, 31, 1'b0);
        snap_fc  = 16'd0;
        snap_req = 1'b1;
        send_nib(1'b1, frame_buf[31][3:0]);
        snap_req = 1'b0;
        send_nib(1'b1, frame_buf[31][7:4]);
        reset = 1'b1;
        send_bytes(32, 64, 1'b0);
        gap(4);
        fill_nominal();
        good_frame(64, 24'h040000, 16'd1);

        gap(4);
        end_req = 1'b1;
        send_nib(1'b0, 4'h0);
        end_req = 1'b0;
        gap(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
